// File: rtl/traffic_phase_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | traffic_phase_scheduler                                                    |
// | Round-robin intersection phase sequencer with demand-sized greens and     |
// | emergency pre-emption.                                                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module traffic_phase_scheduler #(
   parameter int NUM_DIR     = 4,
   parameter int CNT_W       = 8,
   parameter int GREEN_LONG  = 60,
   parameter int GREEN_MED   = 30,
   parameter int GREEN_SHORT = 15,
   parameter int YELLOW_T    = 3,
   parameter int ALLRED_T    = 2,
   parameter int SKIP_EMPTY  = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_DIR-1:0]           sensor_near,
   input  logic [NUM_DIR-1:0]           sensor_far,
   input  logic                         preempt_req,
   input  logic [$clog2(NUM_DIR)-1:0]   preempt_dir,
   output logic [2*NUM_DIR-1:0]         light,
   output logic [$clog2(NUM_DIR)-1:0]   active_dir,
   output logic [1:0]                   phase,
   output logic [CNT_W-1:0]             timer
);

   localparam int DIR_W = $clog2(NUM_DIR);

   localparam logic [1:0] c_st_all_red = 2'b00;
   localparam logic [1:0] c_st_green   = 2'b01;
   localparam logic [1:0] c_st_yellow  = 2'b10;
   localparam logic [1:0] c_st_preempt = 2'b11;

   localparam logic [1:0] c_lt_red    = 2'b00;
   localparam logic [1:0] c_lt_green  = 2'b01;
   localparam logic [1:0] c_lt_yellow = 2'b10;

   localparam logic [CNT_W-1:0] c_long_ld   = CNT_W'(GREEN_LONG - 1);
   localparam logic [CNT_W-1:0] c_med_ld    = CNT_W'(GREEN_MED - 1);
   localparam logic [CNT_W-1:0] c_short_ld  = CNT_W'(GREEN_SHORT - 1);
   localparam logic [CNT_W-1:0] c_yellow_ld = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] c_allred_ld = CNT_W'(ALLRED_T - 1);
   localparam logic [DIR_W-1:0] c_last_dir  = DIR_W'(NUM_DIR - 1);

   generate
      if (NUM_DIR < 2 || NUM_DIR > 8) begin : g_bad_num_dir
         $error("traffic_phase_scheduler: NUM_DIR must lie in 2..8");
      end
      if (GREEN_LONG  < 1 || GREEN_LONG  > (1 << CNT_W) - 1 ||
          GREEN_MED   < 1 || GREEN_MED   > (1 << CNT_W) - 1 ||
          GREEN_SHORT < 1 || GREEN_SHORT > (1 << CNT_W) - 1 ||
          YELLOW_T    < 1 || YELLOW_T    > (1 << CNT_W) - 1 ||
          ALLRED_T    < 1 || ALLRED_T    > (1 << CNT_W) - 1) begin : g_bad_duration
         $error("traffic_phase_scheduler: durations must lie in 1..2^CNT_W-1");
      end
   endgenerate

   logic [1:0]         r_state;
   logic [1:0]         w_next_state;
   logic [CNT_W-1:0]   r_timer;
   logic [CNT_W-1:0]   w_next_timer;
   logic [CNT_W-1:0]   w_green_ld;
   logic [DIR_W-1:0]   r_active;
   logic [DIR_W-1:0]   w_next_active;
   logic [DIR_W-1:0]   w_sel_dir;
   logic [NUM_DIR-1:0] w_demand;
   logic               w_expired;
   logic               w_pdir_ok;

   // (base + offset) mod NUM_DIR for offset in 0..NUM_DIR
   function automatic logic [DIR_W-1:0] f_wrap(input logic [DIR_W-1:0] base,
                                                input int unsigned      offset);
      int unsigned v;
      v = 32'(base) + offset;
      if (v >= unsigned'(NUM_DIR)) v = v - unsigned'(NUM_DIR);
      return v[DIR_W-1:0];
   endfunction

   assign w_demand  = sensor_near | sensor_far;
   assign w_expired = (r_timer == '0);
   assign w_pdir_ok = (32'(preempt_dir) < unsigned'(NUM_DIR));

   // Scanning from the farthest offset down leaves the nearest demanding approach selected.
   always_comb begin
      w_sel_dir = f_wrap(r_active, 1);
      if (SKIP_EMPTY != 0) begin
         for (int k = NUM_DIR; k >= 1; k--) begin
            if (w_demand[f_wrap(r_active, unsigned'(k))]) begin
               w_sel_dir = f_wrap(r_active, unsigned'(k));
            end
         end
      end
   end

   always_comb begin
      if (sensor_far[w_sel_dir]) begin
         w_green_ld = c_long_ld;
      end else if (sensor_near[w_sel_dir]) begin
         w_green_ld = c_med_ld;
      end else begin
         w_green_ld = c_short_ld;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= c_st_all_red;
         r_timer  <= c_allred_ld;
         r_active <= c_last_dir;
      end else begin
         r_state  <= w_next_state;
         r_timer  <= w_next_timer;
         r_active <= w_next_active;
      end
   end

   always_comb begin
      w_next_state  = r_state;
      w_next_timer  = r_timer - CNT_W'(1);
      w_next_active = r_active;
      case (r_state)
         c_st_all_red: begin
            if (w_expired) begin
               if (preempt_req && w_pdir_ok) begin
                  w_next_state  = c_st_preempt;
                  w_next_active = preempt_dir;
                  w_next_timer  = r_timer;
               end else begin
                  w_next_state  = c_st_green;
                  w_next_active = w_sel_dir;
                  w_next_timer  = w_green_ld;
               end
            end
         end
         c_st_green: begin
            if (preempt_req && (preempt_dir == r_active)) begin
               w_next_state = c_st_preempt;
               w_next_timer = r_timer;
            end else if (preempt_req || w_expired) begin
               w_next_state = c_st_yellow;
               w_next_timer = c_yellow_ld;
            end
         end
         c_st_yellow: begin
            if (w_expired) begin
               w_next_state = c_st_all_red;
               w_next_timer = c_allred_ld;
            end
         end
         default: begin
            // Pre-emption holds the timer; preempt_dir is no longer consulted here.
            w_next_timer = r_timer;
            if (!preempt_req) begin
               w_next_state = c_st_yellow;
               w_next_timer = c_yellow_ld;
            end
         end
      endcase
   end

   always_comb begin
      light      = '0;
      phase      = r_state;
      active_dir = r_active;
      timer      = r_timer;
      for (int d = 0; d < NUM_DIR; d++) begin
         if (DIR_W'(d) == r_active) begin
            case (r_state)
               c_st_green, c_st_preempt: light[2*d +: 2] = c_lt_green;
               c_st_yellow:              light[2*d +: 2] = c_lt_yellow;
               default:                  light[2*d +: 2] = c_lt_red;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_traffic_phase_scheduler                                                 |
// | Directed and random stimulus on two instances (SKIP_EMPTY 0 and 1).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_traffic_phase_scheduler;

   localparam int GL = 6;
   localparam int GM = 4;
   localparam int GS = 2;
   localparam int YT = 2;
   localparam int AT = 1;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] near;
   logic [3:0] far;
   logic       preq;
   logic [1:0] pdir;
   logic [7:0] light0, light1;
   logic [1:0] act0, act1, ph0, ph1;
   logic [7:0] tmr0, tmr1;

   always #5 clk = ~clk;

   traffic_phase_scheduler #(
      .NUM_DIR(4), .CNT_W(8), .GREEN_LONG(GL), .GREEN_MED(GM), .GREEN_SHORT(GS),
      .YELLOW_T(YT), .ALLRED_T(AT), .SKIP_EMPTY(0)
   ) u_dut0 (
      .clk(clk), .rst_n(rst_n), .sensor_near(near), .sensor_far(far),
      .preempt_req(preq), .preempt_dir(pdir), .light(light0),
      .active_dir(act0), .phase(ph0), .timer(tmr0)
   );

   traffic_phase_scheduler #(
      .NUM_DIR(4), .CNT_W(8), .GREEN_LONG(GL), .GREEN_MED(GM), .GREEN_SHORT(GS),
      .YELLOW_T(YT), .ALLRED_T(AT), .SKIP_EMPTY(1)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n), .sensor_near(near), .sensor_far(far),
      .preempt_req(preq), .preempt_dir(pdir), .light(light1),
      .active_dir(act1), .phase(ph1), .timer(tmr1)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Reference model: phase 0 all-red, 1 green, 2 yellow, 3 pre-empt; m_left counts cycles left.
   int m_ph[2], m_own[2], m_left[2];
   int pk[2], pd[2];
   int cur[2], len[2];
   int q0[$], q1[$];

   function automatic int pick(int own, int skip);
      for (int k = 1; k <= 4 && skip != 0; k++) begin
         if (near[(own + k) % 4] || far[(own + k) % 4]) return (own + k) % 4;
      end
      return (own + 1) % 4;
   endfunction

   function automatic int gdur(int d);
      if (far[d]) return GL;
      if (near[d]) return GM;
      return GS;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_ph[i] = 0; m_own[i] = 3; m_left[i] = AT;
         pk[i] = 0; pd[i] = 0; cur[i] = -1; len[i] = 0;
      end
      q0.delete();
      q1.delete();
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         case (m_ph[i])
            0: if (m_left[i] == 1) begin
                  if (preq) begin
                     m_ph[i] = 3; m_own[i] = int'(pdir);
                  end else begin
                     m_own[i] = pick(m_own[i], i); m_left[i] = gdur(m_own[i]); m_ph[i] = 1;
                  end
               end else m_left[i]--;
            1: if (preq && int'(pdir) == m_own[i]) m_ph[i] = 3;
               else if (preq || m_left[i] == 1) begin m_ph[i] = 2; m_left[i] = YT; end
               else m_left[i]--;
            2: if (m_left[i] == 1) begin m_ph[i] = 0; m_left[i] = AT; end
               else m_left[i]--;
            default: if (!preq) begin m_ph[i] = 2; m_left[i] = YT; end
         endcase
      end
   endtask

   function automatic logic [7:0] exp_light(int i);
      int code;
      code = (m_ph[i] == 1 || m_ph[i] == 3) ? 1 : (m_ph[i] == 2) ? 2 : 0;
      return 8'(code << (2 * m_own[i]));
   endfunction

   task automatic compare_all();
      check("phase0", ph0,    m_ph[0]);   check("phase1", ph1,    m_ph[1]);
      check("dir0",   act0,   m_own[0]);  check("dir1",   act1,   m_own[1]);
      check("timer0", tmr0,   m_left[0] - 1);
      check("timer1", tmr1,   m_left[1] - 1);
      check("light0", light0, exp_light(0));
      check("light1", light1, exp_light(1));
   endtask

   // Lights must show one approach at most, never 11, and go red -> green -> yellow -> red.
   task automatic check_invariants();
      for (int i = 0; i < 2; i++) begin
         logic [7:0] l;
         int cnt, bad, kind, dir, legal;
         l = (i == 0) ? light0 : light1;
         cnt = 0; bad = 0; kind = 0; dir = 0;
         for (int d = 0; d < 4; d++) begin
            if (l[2*d +: 2] != 2'b00) begin cnt++; kind = int'(l[2*d +: 2]); dir = d; end
            if (l[2*d +: 2] == 2'b11) bad = 1;
         end
         check($sformatf("no11_%0d", i), bad, 0);
         check($sformatf("onehot_%0d", i), (cnt <= 1), 1);
         legal = ((kind == pk[i]) && (kind == 0 || dir == pd[i])) ||
                 (pk[i] == 0 && kind == 1) ||
                 (pk[i] == 1 && kind == 2 && dir == pd[i]) ||
                 (pk[i] == 2 && kind == 0);
         check($sformatf("order_%0d", i), legal, 1);
         pk[i] = kind; pd[i] = dir;
      end
   endtask

   // Records completed green runs as dir*256+length.
   task automatic track();
      for (int i = 0; i < 2; i++) begin
         logic [7:0] l;
         int g;
         l = (i == 0) ? light0 : light1;
         g = -1;
         for (int d = 0; d < 4; d++) if (l[2*d +: 2] == 2'b01) g = d;
         if (g == cur[i] && g >= 0) len[i]++;
         else begin
            if (cur[i] >= 0) begin
               if (i == 0) q0.push_back(cur[i] * 256 + len[i]);
               else        q1.push_back(cur[i] * 256 + len[i]);
            end
            cur[i] = g;
            len[i] = (g >= 0) ? 1 : 0;
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
      compare_all();
      check_invariants();
      track();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_light0", light0, 0); check("rst_light1", light1, 0);
      check("rst_phase0", ph0, 0);    check("rst_dir1",   act1, 3);
      check("rst_timer0", tmr0, AT - 1);
      model_reset();
      cycle();
      cycle();
      rst_n = 1'b1;
   endtask

   function automatic int qget(int which, int k);
      if (which == 0) return (k < q0.size()) ? q0[k] : -1;
      return (k < q1.size()) ? q1[k] : -1;
   endfunction

   initial begin
      int n;
      int held;
      near = '0; far = '0; preq = 1'b0; pdir = '0;
      #2;
      do_reset();

      // Round robin with no demand, no skipping: 0,1,2,3,0 each two cycles.
      repeat (30) cycle();
      for (int k = 0; k < 5; k++) check($sformatf("rr_run%0d", k), qget(0, k), (k % 4) * 256 + GS);

      // far[2] and near[1] with skipping: 1 (med), 2 (long), 1 again.
      near = 4'b0010; far = 4'b0100;
      do_reset();
      repeat (30) cycle();
      check("skip_run0", qget(1, 0), 1 * 256 + GM);
      check("skip_run1", qget(1, 1), 2 * 256 + GL);
      check("skip_run2", qget(1, 2), 1 * 256 + GM);

      // Pre-emption to approach 3 raised during green 0.
      near = '0; far = '0;
      do_reset();
      n = 0;
      while (ph0 != 2'b01 && n < 20) begin cycle(); n++; end
      check("pre_green_wait", ph0, 1);
      cycle();
      preq = 1'b1; pdir = 2'd3;
      n = 0;
      while (ph0 != 2'b11 && n < 20) begin cycle(); n++; end
      check("pre_enter", ph0, 3);
      check("pre_dir", act0, 3);
      held = (light0 == 8'b0100_0000) ? 1 : 0;
      repeat (9) begin
         pdir = 2'($urandom);
         cycle();
         if (ph0 == 2'b11 && light0 == 8'b0100_0000) held++;
      end
      check("pre_hold", held, 10);
      preq = 1'b0;
      cycle(); check("pre_yel_a", light0, 8'b1000_0000);
      cycle(); check("pre_yel_b", light0, 8'b1000_0000);
      cycle(); check("pre_allred", ph0, 0);

      // Asynchronous reset in the middle of a yellow.
      n = 0;
      while (ph0 != 2'b10 && n < 20) begin cycle(); n++; end
      check("ar_yel_wait", ph0, 2);
      #3;
      do_reset();
      repeat (8) cycle();
      check("ar_first0", qget(0, 0), 0 * 256 + GS);
      check("ar_first1", qget(1, 0), 0 * 256 + GS);

      // Randomised sensors and pre-emption.
      repeat (10000) begin
         if ($urandom_range(7) == 0) begin
            near = 4'($urandom);
            far  = 4'($urandom) & 4'($urandom);
         end
         if (!preq) begin
            if ($urandom_range(59) == 0) begin preq = 1'b1; pdir = 2'($urandom); end
         end else if ($urandom_range(14) == 0) begin
            preq = 1'b0;
         end else if ($urandom_range(19) == 0) begin
            pdir = 2'($urandom);
         end
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
